// File: rtl/dds_cfg_sequencer.sv
// Front-panel control sequencer for the DDS core.
// Tracks the frequency, step size and waveform selection. Converts the frequency to a
// phase tuning word with an iterative shift-add multiply, then pushes each configuration
// to the DDS core over a valid/ready handshake.
module dds_cfg_sequencer #(
    parameter int unsigned FREQ_W     = 24,
    parameter int unsigned FREQ_MIN   = 1,
    parameter int unsigned FREQ_MAX   = 10000000,
    parameter int unsigned FREQ_INIT  = 1000,
    parameter int unsigned FTW_W      = 32,
    parameter int unsigned FTW_PER_HZ = 3909374
) (
    input  logic             Fg_CLK,
    input  logic             RESETn,
    input  logic             BtnUp,
    input  logic             BtnDn,
    input  logic             BtnStep,
    input  logic             BtnMode,
    input  logic             CfgReady,
    output logic             CfgValid,
    output logic [FTW_W-1:0] FTW,
    output logic [1:0]       WaveSel,
    output logic [2:0]       StepIdx,
    output logic             Busy
);

    localparam int unsigned PROD_W = FREQ_W + 32;
    localparam int unsigned SUM_W  = FREQ_W + 1;
    localparam int unsigned CNT_W  = $clog2(FREQ_W + 1);

    // Pending-bit positions
    localparam int unsigned P_UP   = 0;
    localparam int unsigned P_DN   = 1;
    localparam int unsigned P_STEP = 2;
    localparam int unsigned P_MODE = 3;

    typedef enum logic [2:0] {
        S_INIT,
        S_IDLE,
        S_OP,
        S_MUL,
        S_PUSH
    } state_t;

    typedef enum logic [1:0] {
        OP_UP,
        OP_DN,
        OP_STEP,
        OP_MODE
    } op_t;

    state_t              state;
    op_t                 op;
    op_t                 sel_op;
    logic [3:0]          pend;
    logic [3:0]          pend_set;
    logic [3:0]          pend_clr;
    logic [3:0]          sel_oh;
    logic [FREQ_W-1:0]   freq;
    logic [FREQ_W-1:0]   freq_next;
    logic [FREQ_W-1:0]   step_hz;
    logic [SUM_W-1:0]    up_sum;
    logic [SUM_W-1:0]    dn_floor;
    logic [PROD_W-1:0]   acc;
    logic [PROD_W-1:0]   mcand;
    logic [PROD_W-1:0]   mul_sum;
    logic [FREQ_W-1:0]   mplier;
    logic [CNT_W-1:0]    cnt;

    // Step size in Hz for the current step index
    always_comb begin
        step_hz = FREQ_W'(1);
        case (StepIdx)
            3'd0:    step_hz = FREQ_W'(1);
            3'd1:    step_hz = FREQ_W'(10);
            3'd2:    step_hz = FREQ_W'(100);
            3'd3:    step_hz = FREQ_W'(1000);
            3'd4:    step_hz = FREQ_W'(10000);
            3'd5:    step_hz = FREQ_W'(100000);
            default: step_hz = FREQ_W'(1);
        endcase
    end

    // Saturating frequency update for the latched operation
    always_comb begin
        up_sum    = {1'b0, freq} + {1'b0, step_hz};
        dn_floor  = SUM_W'(FREQ_MIN) + {1'b0, step_hz};
        freq_next = freq;
        case (op)
            OP_UP:   freq_next = (up_sum > SUM_W'(FREQ_MAX)) ? FREQ_W'(FREQ_MAX)
                                                             : up_sum[FREQ_W-1:0];
            OP_DN:   freq_next = ({1'b0, freq} < dn_floor) ? FREQ_W'(FREQ_MIN)
                                                           : freq - step_hz;
            default: freq_next = freq;
        endcase
    end

    // Request selection (MODE > STEP > UP > DN) and pending-bit set/clear
    always_comb begin
        sel_op   = OP_DN;
        sel_oh   = 4'b0000;
        pend_set = {BtnMode, BtnStep, BtnDn, BtnUp};
        if (pend[P_MODE]) begin
            sel_op = OP_MODE;
            sel_oh = 4'b1000;
        end else if (pend[P_STEP]) begin
            sel_op = OP_STEP;
            sel_oh = 4'b0100;
        end else if (pend[P_UP]) begin
            sel_op = OP_UP;
            sel_oh = 4'b0001;
        end else if (pend[P_DN]) begin
            sel_op = OP_DN;
            sel_oh = 4'b0010;
        end
        pend_clr = (state == S_IDLE) ? sel_oh : 4'b0000;
    end

    // One shift-add partial product per MUL cycle
    always_comb begin
        mul_sum = acc + (mplier[0] ? mcand : '0);
    end

    // Sequencer state, configuration registers and multiplier datapath
    always_ff @(posedge Fg_CLK or negedge RESETn) begin
        if (!RESETn) begin
            state    <= S_INIT;
            op       <= OP_UP;
            pend     <= 4'b0000;
            freq     <= FREQ_W'(FREQ_INIT);
            StepIdx  <= 3'd2;
            WaveSel  <= 2'd0;
            acc      <= '0;
            mcand    <= '0;
            mplier   <= '0;
            cnt      <= '0;
            CfgValid <= 1'b0;
            FTW      <= '0;
            Busy     <= 1'b1;
        end else begin
            // set wins over a same-edge clear
            pend <= (pend & ~pend_clr) | pend_set;
            case (state)
                S_INIT: begin
                    acc    <= '0;
                    mcand  <= PROD_W'(FTW_PER_HZ);
                    mplier <= freq;
                    cnt    <= '0;
                    state  <= S_MUL;
                end
                S_IDLE: begin
                    if (|pend) begin
                        op    <= sel_op;
                        state <= S_OP;
                        Busy  <= 1'b1;
                    end
                end
                S_OP: begin
                    freq <= freq_next;
                    if (op == OP_STEP) begin
                        StepIdx <= (StepIdx == 3'd5) ? 3'd0 : StepIdx + 3'd1;
                        state   <= S_IDLE;
                        Busy    <= 1'b0;
                    end else begin
                        if (op == OP_MODE) begin
                            WaveSel <= WaveSel + 2'd1;
                        end
                        acc    <= '0;
                        mcand  <= PROD_W'(FTW_PER_HZ);
                        mplier <= freq_next;
                        cnt    <= '0;
                        state  <= S_MUL;
                    end
                end
                S_MUL: begin
                    acc    <= mul_sum;
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    cnt    <= cnt + CNT_W'(1);
                    if (cnt == CNT_W'(FREQ_W - 1)) begin
                        FTW      <= mul_sum[FTW_W+15:16];
                        CfgValid <= 1'b1;
                        state    <= S_PUSH;
                    end
                end
                S_PUSH: begin
                    if (CfgReady) begin
                        CfgValid <= 1'b0;
                        state    <= S_IDLE;
                        Busy     <= 1'b0;
                    end
                end
                default: begin
                    state <= S_INIT;
                    Busy  <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dds_cfg_sequencer.sv
// Directed bench for dds_cfg_sequencer with hand-computed tuning words.
module tb_dds_cfg_sequencer;

    logic        Fg_CLK   = 1'b0;
    logic        RESETn   = 1'b0;
    logic        BtnUp    = 1'b0;
    logic        BtnDn    = 1'b0;
    logic        BtnStep  = 1'b0;
    logic        BtnMode  = 1'b0;
    logic        CfgReady = 1'b1;
    logic        CfgValid;
    logic [31:0] FTW;
    logic [1:0]  WaveSel;
    logic [2:0]  StepIdx;
    logic        Busy;

    int total = 0;
    int bad   = 0;
    int xfers = 0;

    dds_cfg_sequencer dut (
        .Fg_CLK   (Fg_CLK),
        .RESETn   (RESETn),
        .BtnUp    (BtnUp),
        .BtnDn    (BtnDn),
        .BtnStep  (BtnStep),
        .BtnMode  (BtnMode),
        .CfgReady (CfgReady),
        .CfgValid (CfgValid),
        .FTW      (FTW),
        .WaveSel  (WaveSel),
        .StepIdx  (StepIdx),
        .Busy     (Busy)
    );

    always #5 Fg_CLK = ~Fg_CLK;

    // Count completed handshakes
    always @(posedge Fg_CLK) begin
        if (RESETn && CfgValid && CfgReady) xfers <= xfers + 1;
    end

    task automatic check(input string tag, input longint unsigned got, input longint unsigned exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge Fg_CLK);
            #1;
        end
    endtask

    // b = {mode, step, dn, up}; one-cycle pulse
    task automatic pulse(input logic [3:0] b);
        BtnUp   = b[0];
        BtnDn   = b[1];
        BtnStep = b[2];
        BtnMode = b[3];
        tick(1);
        BtnUp   = 1'b0;
        BtnDn   = 1'b0;
        BtnStep = 1'b0;
        BtnMode = 1'b0;
    endtask

    // Edges until CfgValid is seen high, bounded
    task automatic wait_valid(output int n);
        n = 0;
        do begin
            tick(1);
            n++;
        end while (!CfgValid && n < 200);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int x0;
        int errs;
        logic [31:0] cap_ftw;
        logic [1:0]  cap_wave;

        tick(3);
        check("rst_valid", CfgValid, 0);
        check("rst_ftw",   FTW,      0);
        check("rst_wave",  WaveSel,  0);
        check("rst_step",  StepIdx,  2);
        check("rst_busy",  Busy,     1);

        // power-up push
        RESETn = 1'b1;
        wait_valid(n);
        check("pwr_lat",  n,       25);
        check("pwr_ftw",  FTW,     59652);
        check("pwr_wave", WaveSel, 0);
        check("pwr_step", StepIdx, 2);
        tick(1);
        check("pwr_valid_drop", CfgValid, 0);
        check("pwr_busy_low",   Busy,     0);
        tick(40);
        check("pwr_xfers", xfers, 1);

        // up then down by 100 Hz
        pulse(4'b0001);
        wait_valid(n);
        check("up_lat", n, 26);
        check("up_ftw", FTW, 65617);
        tick(1);
        pulse(4'b0010);
        wait_valid(n);
        check("dn_lat", n, 26);
        check("dn_ftw", FTW, 59652);
        tick(1);

        // step to 100000 Hz, down clamps to 1 Hz
        x0 = xfers;
        for (int i = 0; i < 3; i++) begin
            pulse(4'b0100);
            tick(2);
            check("step_busy", Busy, 0);
        end
        check("step_idx5", StepIdx, 5);
        pulse(4'b0010);
        wait_valid(n);
        check("clamp_ftw", FTW, 59);
        tick(1);
        pulse(4'b0100);
        tick(2);
        pulse(4'b0100);
        tick(2);
        check("step_wrap", StepIdx, 1);
        check("step_no_push", xfers, x0 + 1);
        pulse(4'b0100);
        tick(2);
        check("step_idx2", StepIdx, 2);

        // stall in PUSH with coalesced ups
        CfgReady = 1'b0;
        x0 = xfers;
        pulse(4'b0001);
        wait_valid(n);
        check("stall_lat", n, 26);
        check("stall_ftw", FTW, 6024);
        cap_ftw  = FTW;
        cap_wave = WaveSel;
        errs = 0;
        for (int i = 0; i < 50; i++) begin
            tick(1);
            if (CfgValid !== 1'b1 || FTW !== cap_ftw || WaveSel !== cap_wave) errs++;
            BtnUp = (i == 5 || i == 20 || i == 35);
        end
        BtnUp = 1'b0;
        check("stall_stable", errs, 0);
        check("stall_no_xfer", xfers, x0);
        CfgReady = 1'b1;
        wait_valid(n);
        check("coalesce_lat", n, 27);
        check("coalesce_ftw", FTW, 11990);
        tick(40);
        check("coalesce_xfers", xfers, x0 + 2);

        // mode and up together: mode first
        pulse(4'b1001);
        wait_valid(n);
        check("mode_lat",  n,       26);
        check("mode_wave", WaveSel, 1);
        check("mode_ftw",  FTW,     11990);
        wait_valid(n);
        check("mode_up_lat",  n,       27);
        check("mode_up_wave", WaveSel, 1);
        check("mode_up_ftw",  FTW,     17955);
        for (int k = 2; k <= 4; k++) begin
            tick(1);
            pulse(4'b1000);
            wait_valid(n);
            check("mode_wrap_wave", WaveSel, k % 4);
            check("mode_wrap_ftw",  FTW,     17955);
        end
        tick(1);
        pulse(4'b1000);
        wait_valid(n);
        check("mode5_wave", WaveSel, 1);
        tick(1);
        pulse(4'b0100);
        tick(2);
        check("pre_rst_step", StepIdx, 3);

        // reset in the 10th MUL cycle
        x0 = xfers;
        pulse(4'b0001);
        tick(11);
        check("mul_busy",  Busy,     1);
        check("mul_valid", CfgValid, 0);
        RESETn = 1'b0;
        #1;
        check("arst_valid", CfgValid, 0);
        check("arst_ftw",   FTW,      0);
        check("arst_wave",  WaveSel,  0);
        check("arst_step",  StepIdx,  2);
        check("arst_busy",  Busy,     1);
        tick(1);
        RESETn = 1'b1;
        wait_valid(n);
        check("repwr_lat", n,   25);
        check("repwr_ftw", FTW, 59652);
        tick(40);
        check("repwr_xfers", xfers, x0 + 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
